// File: rtl/lcd_nibble_tx_pkg.sv
// Shared definitions for the LCD nibble physical layer.
// This package holds:
//   - the FSM state encodings, kept as plain localparams so legacy code that
//     compares raw state values still matches;
//   - the default bus timing in clk_i cycles, targeting 50 MHz;
//   - the nibble command layout {rs, rw, data[3:0], del[17:0]} (24 bits),
//     which the upstream byte sequencer and the init sequencer also use;
//   - a small integer max() helper used for sizing.
package lcd_nibble_tx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_ACK   = 3'd5;

  localparam int SETUP_CYC_DEF   = 2;
  localparam int E_PULSE_CYC_DEF = 12;
  localparam int HOLD_CYC_DEF    = 1;
  localparam int DEL_W_DEF       = 18;

  typedef struct packed {
    logic        rs;
    logic        rw;
    logic [3:0]  data;
    logic [17:0] del;
  } nibble_cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// LCD 4-bit bus transmitter. This block takes one nibble request per
// handshake and drives the LCD bus with the required timing.
//
// Each request goes through these phases:
//   1. RS, RW and DB are presented for SETUP_CYC cycles.
//   2. E is pulsed high for E_PULSE_CYC cycles.
//   3. The bus is held for HOLD_CYC cycles after E falls.
//   4. The block waits the requested post-command delay.
//   5. ack_o pulses for one cycle.
//
// Ports:
//   clk_i, reset_i        clock; synchronous active-low reset
//   rq_i / ack_o          level request, held until the one-cycle ack
//   rqRs_i, rqRw_i        RS / RW of the nibble
//   rqData_i              nibble value (goes to DB[7:4])
//   rqDel_i               post-command wait, in clk_i cycles
//   busy_o                high from the accept edge through the ack cycle
//   lcdE_o, lcdRs_o, lcdRw_o, lcdData_o
//                         registered LCD bus
//   lcdDataOe_o           data bus output enable (~RW while busy, 0 when idle)
module lcd_nibble_tx
  import lcd_nibble_tx_pkg::*;
#(
  parameter int SETUP_CYC   = SETUP_CYC_DEF,
  parameter int E_PULSE_CYC = E_PULSE_CYC_DEF,
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int DEL_W       = DEL_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             rq_i,
  output logic             ack_o,
  input  logic             rqRs_i,
  input  logic             rqRw_i,
  input  logic [3:0]       rqData_i,
  input  logic [DEL_W-1:0] rqDel_i,
  output logic             busy_o,
  output logic             lcdE_o,
  output logic             lcdRs_o,
  output logic             lcdRw_o,
  output logic [3:0]       lcdData_o,
  output logic             lcdDataOe_o
);

  localparam int TIM_MAX = max_int(max_int(SETUP_CYC, E_PULSE_CYC), HOLD_CYC);
  localparam int CNT_W   = max_int(DEL_W, $clog2(TIM_MAX + 1));

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [DEL_W-1:0] del_q;
  logic             cnt_done;

  // The counter is loaded with (phase length - 1) on state entry, so the
  // phase ends on the edge where it reads zero. A delay of 2^DEL_W-1 is
  // therefore loaded as 2^DEL_W-2 and fits in the counter.
  assign cnt_done = (cnt == '0);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      del_q       <= '0;
      ack_o       <= 1'b0;
      busy_o      <= 1'b0;
      lcdE_o      <= 1'b0;
      lcdRs_o     <= 1'b0;
      lcdRw_o     <= 1'b0;
      lcdData_o   <= '0;
      lcdDataOe_o <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rq_i) begin
            // Capture the request. Upstream may change its inputs from here on.
            lcdRs_o     <= rqRs_i;
            lcdRw_o     <= rqRw_i;
            lcdData_o   <= rqData_i;
            lcdDataOe_o <= ~rqRw_i;
            del_q       <= rqDel_i;
            busy_o      <= 1'b1;
            state       <= ST_SETUP;
            cnt         <= CNT_W'(SETUP_CYC - 1);
          end
        end
        ST_SETUP: begin
          if (cnt_done) begin
            state  <= ST_PULSE;
            lcdE_o <= 1'b1;
            cnt    <= CNT_W'(E_PULSE_CYC - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt_done) begin
            state  <= ST_HOLD;
            lcdE_o <= 1'b0;
            cnt    <= CNT_W'(HOLD_CYC - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_done) begin
            if (del_q != '0) begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(del_q - DEL_W'(1));
            end else begin
              state <= ST_ACK;
              ack_o <= 1'b1;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt_done) begin
            state <= ST_ACK;
            ack_o <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_ACK: begin
          // rq_i is deliberately not examined here, so a request that is
          // still high in the ack cycle cannot be issued a second time.
          state       <= ST_IDLE;
          busy_o      <= 1'b0;
          lcdDataOe_o <= 1'b0;
          cnt         <= '0;
        end
        default: begin
          state       <= ST_IDLE;
          cnt         <= '0;
          busy_o      <= 1'b0;
          lcdE_o      <= 1'b0;
          lcdDataOe_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_tx.sv
module tb_lcd_nibble_tx;

  localparam int S  = 2;
  localparam int EP = 12;
  localparam int H  = 1;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        rq_i = 1'b0;
  logic        rqRs_i = 1'b0;
  logic        rqRw_i = 1'b0;
  logic [3:0]  rqData_i = 4'h0;
  logic [17:0] rqDel_i = 18'h0;
  logic        ack_o, busy_o, lcdE_o, lcdRs_o, lcdRw_o, lcdDataOe_o;
  logic [3:0]  lcdData_o;

  // Second instance with a narrow delay field, so the full-scale delay
  // boundary can be exercised in a short run.
  logic        rq_s = 1'b0;
  logic [9:0]  rqDel_s = 10'h0;
  logic        ack_s, busy_s, lcdE_s, lcdRs_s, lcdRw_s, lcdDataOe_s;
  logic [3:0]  lcdData_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lcd_nibble_tx dut (
    .clk_i(clk), .reset_i(reset_i), .rq_i(rq_i), .ack_o(ack_o),
    .rqRs_i(rqRs_i), .rqRw_i(rqRw_i), .rqData_i(rqData_i), .rqDel_i(rqDel_i),
    .busy_o(busy_o), .lcdE_o(lcdE_o), .lcdRs_o(lcdRs_o), .lcdRw_o(lcdRw_o),
    .lcdData_o(lcdData_o), .lcdDataOe_o(lcdDataOe_o)
  );

  lcd_nibble_tx #(.DEL_W(10)) dut_s (
    .clk_i(clk), .reset_i(reset_i), .rq_i(rq_s), .ack_o(ack_s),
    .rqRs_i(1'b1), .rqRw_i(1'b0), .rqData_i(4'h6), .rqDel_i(rqDel_s),
    .busy_o(busy_s), .lcdE_o(lcdE_s), .lcdRs_o(lcdRs_s), .lcdRw_o(lcdRw_s),
    .lcdData_o(lcdData_s), .lcdDataOe_o(lcdDataOe_s)
  );

  // Global pulse / ack counters for the main instance.
  int   e_rises = 0;
  int   acks = 0;
  logic e_prev = 1'b0;
  always @(negedge clk) begin
    if (lcdE_o && !e_prev) e_rises <= e_rises + 1;
    if (ack_o) acks <= acks + 1;
    e_prev <= lcdE_o;
  end

  typedef struct {
    logic       rs;
    logic       rw;
    logic [3:0] data;
    int         del;
    int         ack;
    int         ef;
    int         el;
  } vec_t;

  typedef struct {
    int e_first;
    int e_last;
    int e_cnt;
    int ack_cyc;
    int d_at_e;
    int bus_err;
    int busy_err;
    int post_busy;
    int post_oe;
    int post_ack;
  } obs_t;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference timeline: cycle numbers are counted from the accept edge (edge 0).
  function automatic int model_ack(input int del);
    return S + EP + H + del + 1;
  endfunction

  // Runs one request, following the upstream protocol. Every cycle up to the
  // ack is observed, then one further cycle.
  task automatic run_txn(input logic rs, input logic rw, input logic [3:0] d,
                         input int del, input bit chg, input bit hold_rq,
                         output obs_t o);
    int limit;
    limit = model_ack(del) + 40;
    o = '{default: 0};
    o.e_first = -1;
    o.ack_cyc = -1;
    o.d_at_e  = -1;
    rqRs_i = rs; rqRw_i = rw; rqData_i = d; rqDel_i = 18'(del); rq_i = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (k == 1 && chg) rqData_i = ~d;
      if (lcdE_o) begin
        if (o.e_first < 0) begin
          o.e_first = k;
          o.d_at_e  = int'(lcdData_o);
        end
        o.e_last = k;
        o.e_cnt++;
      end
      if ({lcdRs_o, lcdRw_o, lcdData_o, lcdDataOe_o} != {rs, rw, d, ~rw}) o.bus_err++;
      if (!busy_o) o.busy_err++;
      if (ack_o) begin
        o.ack_cyc = k;
        if (!hold_rq) rq_i = 1'b0;
        break;
      end
    end
    if (o.ack_cyc < 0) begin
      rq_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rq_i = 1'b0;
    o.post_busy = int'(busy_o);
    o.post_oe   = int'(lcdDataOe_o);
    o.post_ack  = int'(ack_o);
  endtask

  task automatic check_txn(input string tag, input obs_t o, input int ack,
                           input int ef, input int el, input logic [3:0] d);
    chk({tag, " ack_cycle"}, o.ack_cyc, ack);
    chk({tag, " e_first"}, o.e_first, ef);
    chk({tag, " e_last"}, o.e_last, el);
    chk({tag, " e_count"}, o.e_cnt, el - ef + 1);
    chk({tag, " data_at_e"}, o.d_at_e, int'(d));
    chk({tag, " bus_errors"}, o.bus_err, 0);
    chk({tag, " busy_gaps"}, o.busy_err, 0);
    chk({tag, " busy_after"}, o.post_busy, 0);
    chk({tag, " oe_after"}, o.post_oe, 0);
    chk({tag, " ack_width"}, o.post_ack, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    obs_t o;
    logic [3:0] b2b[4];
    int r0, a0, bad, cyc;

    tbl[0] = '{1'b1, 1'b0, 4'hA, 30, 46, 3, 14};
    tbl[1] = '{1'b0, 1'b0, 4'h5, 0, 16, 3, 14};
    tbl[2] = '{1'b0, 1'b1, 4'hF, 7, 23, 3, 14};
    tbl[3] = '{1'b1, 1'b1, 4'h0, 1, 17, 3, 14};
    tbl[4] = '{1'b1, 1'b0, 4'h9, 100, 116, 3, 14};
    b2b[0] = 4'h8; b2b[1] = 4'h0; b2b[2] = 4'h4; b2b[3] = 4'h1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({ack_o, busy_o, lcdE_o, lcdRs_o, lcdRw_o, lcdData_o, lcdDataOe_o}), 0);
    chk("reset_outputs_s", int'({ack_s, busy_s, lcdE_s, lcdRs_s, lcdRw_s, lcdData_s, lcdDataOe_s}), 0);
    reset_i = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i].rs, tbl[i].rw, tbl[i].data, tbl[i].del, 1'b0, 1'b0, o);
      check_txn($sformatf("tbl%0d", i), o, tbl[i].ack, tbl[i].ef, tbl[i].el, tbl[i].data);
    end

    // Randomized requests against the timeline model.
    for (int i = 0; i < 20; i++) begin
      logic rs, rw;
      logic [3:0] d;
      int del;
      bit chg;
      rs  = 1'($urandom);
      rw  = 1'($urandom);
      d   = 4'($urandom);
      del = int'($urandom_range(0, 40));
      chg = bit'($urandom_range(0, 1));
      run_txn(rs, rw, d, del, chg, 1'b0, o);
      check_txn($sformatf("rnd%0d", i), o, model_ack(del), S + 1, S + EP, d);
    end

    // Upstream data changes right after accept: the latched copy must stay.
    run_txn(1'b1, 1'b0, 4'h3, 5, 1'b1, 1'b0, o);
    check_txn("data_change", o, model_ack(5), S + 1, S + EP, 4'h3);

    // rq still high through the ack edge must not start a second transfer.
    r0 = e_rises;
    run_txn(1'b0, 1'b0, 4'h7, 2, 1'b0, 1'b1, o);
    check_txn("rq_in_ack", o, model_ack(2), S + 1, S + EP, 4'h7);
    repeat (20) @(posedge clk);
    #1;
    chk("rq_in_ack_pulses", e_rises - r0, 1);

    // Back-to-back nibbles using the upstream protocol.
    r0 = e_rises;
    a0 = acks;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b0, b2b[i], 3, 1'b0, 1'b0, o);
      check_txn($sformatf("b2b%0d", i), o, model_ack(3), S + 1, S + EP, b2b[i]);
    end
    repeat (30) @(posedge clk);
    #1;
    chk("b2b_pulses", e_rises - r0, 4);
    chk("b2b_acks", acks - a0, 4);

    // Reset during the enable pulse (cycle 8).
    a0 = acks;
    rqRs_i = 1'b1; rqRw_i = 1'b0; rqData_i = 4'h2; rqDel_i = 18'd10; rq_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
    end
    chk("mid_reset_e_before", int'(lcdE_o), 1);
    reset_i = 1'b0;
    rq_i = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset_e", int'(lcdE_o), 0);
    chk("mid_reset_busy", int'(busy_o), 0);
    chk("mid_reset_oe", int'(lcdDataOe_o), 0);
    reset_i = 1'b1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (busy_o || lcdE_o || ack_o) bad++;
    end
    chk("mid_reset_quiet", bad, 0);
    chk("mid_reset_no_ack", acks - a0, 0);
    run_txn(1'b0, 1'b0, 4'hB, 4, 1'b0, 1'b0, o);
    check_txn("after_reset", o, model_ack(4), S + 1, S + EP, 4'hB);

    // Full-scale delay on the narrow instance: 2^10-1 cycles.
    rqDel_s = 10'h3FF;
    rq_s = 1'b1;
    cyc = -1;
    bad = 0;
    for (int k = 1; k <= model_ack(1023) + 50; k++) begin
      @(posedge clk); #1;
      if (!busy_s) bad++;
      if (ack_s) begin
        cyc = k;
        rq_s = 1'b0;
        break;
      end
    end
    rq_s = 1'b0;
    chk("maxdel_ack_cycle", cyc, model_ack(1023));
    chk("maxdel_busy_gaps", bad, 0);
    @(posedge clk); #1;
    chk("maxdel_busy_after", int'(busy_s), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_tx.md
Name: lcd_nibble_tx

Overview:
- Physical-layer stage directly downstream of the byte-to-nibble sequencer.
- Accepts one nibble request {RS, RW, data[3:0], delay[17:0]} per handshake and drives the 4-bit LCD bus with setup, enable-pulse and hold timing.
- Then waits the requested post-command delay and returns a one-cycle ack.
- Delay is in clk_i cycles; 50 MHz is the design target.

Parameters:
- SETUP_CYC, 2: cycles RS/RW/DB are stable before E rises (>=1).
- E_PULSE_CYC, 12: cycles E is high (>=1).
- HOLD_CYC, 1: cycles bus is held after E falls (>=1).
- DEL_W, 18: width of the delay field.

Ports:
- clk_i, in, 1: single clock, rising edge.
- reset_i, in, 1: synchronous, active-low reset.
- rq_i, in, 1: nibble request from upstream; level, held until ack_o.
- ack_o, out, 1: one-cycle completion pulse.
- rqRs_i, in, 1: register select for this nibble.
- rqRw_i, in, 1: read/write for this nibble.
- rqData_i, in, 4: nibble value.
- rqDel_i, in, DEL_W: post-command wait in cycles.
- busy_o, out, 1: high from accept through ack cycle.
- lcdE_o, out, 1: LCD enable.
- lcdRs_o, out, 1: LCD RS.
- lcdRw_o, out, 1: LCD RW.
- lcdData_o, out, 4: LCD DB[7:4].
- lcdDataOe_o, out, 1: data bus output enable; equals ~RW while busy, 0 when idle.

Behaviour:
- All outputs are registered. When reset_i=0 at a clock edge, the next state is IDLE, lcdE_o=0, lcdRs_o=0, lcdRw_o=0, lcdData_o=0, lcdDataOe_o=0, ack_o=0, busy_o=0. Reset mid-transfer aborts immediately, E drops on that edge, and no ack is produced.
- States: IDLE, SETUP, PULSE, HOLD, WAIT, ACK. A single down-counter, max(DEL_W, width of largest timing parameter) bits, is reloaded on every state entry.
- IDLE: on an edge with rq_i=1, latch rqRs_i, rqRw_i, rqData_i and rqDel_i into lcd outputs and the delay register. lcdDataOe_o <= ~rqRw_i, busy_o <= 1, go to SETUP with count SETUP_CYC. Upstream inputs may change after acceptance; only the latched copy is used.
- SETUP: SETUP_CYC cycles with E=0, then PULSE.
- PULSE: E_PULSE_CYC cycles with lcdE_o=1, then HOLD.
- HOLD: HOLD_CYC cycles with E=0 and bus unchanged. Next state is WAIT if the latched delay is non-zero, otherwise ACK.
- WAIT: exactly delay cycles, then ACK. The bus stays held.
- ACK: one cycle with ack_o=1 and busy_o=1. Next state is IDLE, with busy_o, ack_o and lcdDataOe_o cleared.
- Latency: the accept edge is edge 0. ack_o is high in cycle SETUP_CYC+E_PULSE_CYC+HOLD_CYC+del+1. With defaults and del=30 that is cycle 46; with del=0 it is cycle 16.
- rq_i is ignored outside IDLE, including the ACK cycle. Upstream clears rq in the cycle after ack, so the earliest re-accept is the first IDLE cycle in which rq_i=1. This gives no double issue and no lost request.
- Maximum delay 2^DEL_W-1 completes without counter overflow.
- Reads (RW=1): E is still pulsed and lcdDataOe_o=0; read data is not captured.

Decomposition:
- Shared header lcd_defs.vh holds:
  - state encodings;
  - default timing localparams (SETUP_CYC, E_PULSE_CYC, HOLD_CYC);
  - the nibble command field layout {rs, rw, data[3:0], del[17:0]} = 24 bits, shared with the upstream sequencer and the init sequencer.
- No sub-module is needed; FSM and counter live in one module.

Test Plan:
- Single write with rs=1, rw=0, data=4'hA, del=30 (defaults) -> lcdRs_o=1 and lcdData_o=A from cycle 1; lcdE_o high in cycles 3-14; ack_o high only in cycle 46; busy_o low in cycle 47.
- del=0 -> ack_o in cycle 16 and WAIT never entered. del=2^18-1 -> ack_o exactly at cycle 16+262143.
- Change rqData_i from 4'h3 to 4'hC one cycle after accept -> lcdData_o stays 3 until ack.
- Back-to-back: drive the upstream protocol (rq dropped the cycle after ack, re-raised the next cycle) with four nibbles {0x8,0x0,0x4,0x1} -> exactly four E pulses carrying those values in order, four acks, no extra pulse.
- reset_i=0 during PULSE (cycle 8) -> lcdE_o=0 and busy_o=0 from the next cycle, and no ack_o. A following request then completes normally.
- Read nibble with rw=1 -> lcdDataOe_o=0 throughout, E is pulsed for 12 cycles, and ack_o is timed as for a write.
